// File: rtl/conv_pkg.sv
// conv_pkg: FSM state encoding and job-size constants shared by the
// convolution-engine arbiter and its bench.
package conv_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t LOAD  = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t DRAIN = 2'd3;

    localparam int N_IFM = 49;
    localparam int N_WGT = 9;
    localparam int N_OFM = 25;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick (combinational) with a registered
// priority pointer. Ports: clk, rst_n, req[1:0], take (commit the pick),
// gnt[1:0] one-hot pick (zero when no request).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    // prio_q = 1 means requester 1 wins a tie
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end
        prio_d = prio_q;
        // whoever is served now loses the next tie
        if (take && (gnt != 2'b00)) begin
            prio_d = gnt[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/conv_arbiter.sv
// conv_arbiter: shares one 7x7 IFM / 3x3 weight convolution engine between
// two requesters, one job at a time (IDLE -> LOAD -> WAIT -> DRAIN).
// Ports: clk, rst_n; req, src_valid, src_wvalid, src_ifm0/1, src_wgt0/1
// from requesters; gnt one-hot grant; eng_* to/from the engine;
// rsp_valid/rsp_data results; done per-requester job pulse; err watchdog.
// Build option: define CONV_ARB_TIMEOUT_EN to enable the WAIT watchdog.
module conv_arbiter #(
    parameter int N_IFM   = conv_pkg::N_IFM,
    parameter int N_WGT   = conv_pkg::N_WGT,
    parameter int N_OFM   = conv_pkg::N_OFM,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  src_valid,
    input  logic [1:0]  src_wvalid,
    input  logic [15:0] src_ifm0,
    input  logic [15:0] src_ifm1,
    input  logic [15:0] src_wgt0,
    input  logic [15:0] src_wgt1,
    output logic [1:0]  gnt,
    output logic        eng_in_valid,
    output logic        eng_weight_valid,
    output logic [15:0] eng_ifm,
    output logic [15:0] eng_weight,
    input  logic        eng_out_valid,
    input  logic [35:0] eng_ofm,
    output logic [1:0]  rsp_valid,
    output logic [35:0] rsp_data,
    output logic [1:0]  done,
    output logic        err
);

    import conv_pkg::*;

    // counters are 6 bits wide and must never wrap inside a job
    if (N_IFM < 1 || N_IFM > 63 || N_WGT < 1 || N_WGT > 63 ||
        N_OFM < 1 || N_OFM > 63 || TIMEOUT < 1 || TIMEOUT > 127)
    begin : g_bad_cfg
        $error("conv_arbiter: parameter out of range");
    end

    localparam logic [5:0] IFM_LAST = 6'(N_IFM - 1);
    localparam logic [5:0] OFM_LAST = 6'(N_OFM - 1);

    state_t      state_q, state_d;
    logic [5:0]  ifm_cnt_q, ifm_cnt_d;
    logic [5:0]  wgt_cnt_q, wgt_cnt_d;
    logic [5:0]  ofm_cnt_q, ofm_cnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [35:0] rsp_data_q, rsp_data_d;
    logic [1:0]  done_q, done_d;

    logic [1:0]  arb_gnt;
    logic        in_load;
    logic        res_take;
    logic        res_last;
    logic        tmo_hit;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .take  (state_q == IDLE),
        .gnt   (arb_gnt)
    );

    // zero-latency mux of the granted source; everything else masked
    assign in_load = (state_q == LOAD);

    assign eng_in_valid = in_load
                       && ((src_valid & gnt_q) != 2'b00)
                       && (ifm_cnt_q < 6'(N_IFM));

    assign eng_weight_valid = in_load
                           && ((src_wvalid & gnt_q) != 2'b00)
                           && (wgt_cnt_q < 6'(N_WGT));

    assign eng_ifm = !eng_in_valid ? 16'h0000
                   : (gnt_q[1] ? src_ifm1 : src_ifm0);

    assign eng_weight = !eng_weight_valid ? 16'h0000
                      : (gnt_q[1] ? src_wgt1 : src_wgt0);

    assign res_take = eng_out_valid
                   && ((state_q == WAIT) || (state_q == DRAIN))
                   && (ofm_cnt_q < 6'(N_OFM));

    assign res_last = res_take && (ofm_cnt_q == OFM_LAST);

`ifdef CONV_ARB_TIMEOUT_EN
    logic [6:0] tmo_cnt_q, tmo_cnt_d;
    logic       err_q, err_d;

    assign tmo_hit = (state_q == WAIT) && !eng_out_valid
                  && (tmo_cnt_q == 7'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = 7'd0;
        if ((state_q == WAIT) && !eng_out_valid) begin
            tmo_cnt_d = tmo_cnt_q + 7'd1;
        end
        err_d = tmo_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 7'd0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ifm_cnt_d   = ifm_cnt_q;
        wgt_cnt_d   = wgt_cnt_q;
        ofm_cnt_d   = ofm_cnt_q;
        gnt_d       = gnt_q;
        rsp_valid_d = 2'b00;
        rsp_data_d  = 36'h0;
        done_d      = 2'b00;

        if (res_take) begin
            rsp_valid_d = gnt_q;
            rsp_data_d  = eng_ofm;
            ofm_cnt_d   = ofm_cnt_q + 6'd1;
        end
        if (res_last) begin
            done_d = gnt_q;
        end

        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = LOAD;
                    gnt_d   = arb_gnt;
                end
            end
            LOAD: begin
                if (eng_in_valid) begin
                    ifm_cnt_d = ifm_cnt_q + 6'd1;
                end
                if (eng_weight_valid) begin
                    wgt_cnt_d = wgt_cnt_q + 6'd1;
                end
                if (eng_in_valid && (ifm_cnt_q == IFM_LAST)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (res_take) begin
                    state_d = res_last ? IDLE : DRAIN;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (res_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // entering IDLE ends the job: release grant, clear counters
        if ((state_d == IDLE) && (state_q != IDLE)) begin
            gnt_d     = 2'b00;
            ifm_cnt_d = 6'd0;
            wgt_cnt_d = 6'd0;
            ofm_cnt_d = 6'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ifm_cnt_q   <= 6'd0;
            wgt_cnt_q   <= 6'd0;
            ofm_cnt_q   <= 6'd0;
            gnt_q       <= 2'b00;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= 36'h0;
            done_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            ifm_cnt_q   <= ifm_cnt_d;
            wgt_cnt_q   <= wgt_cnt_d;
            ofm_cnt_q   <= ofm_cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            done_q      <= done_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_arbiter.sv
// tb_conv_arbiter: directed table vectors plus hand-written job sequences
// for conv_arbiter (grant, streaming masks, results, reset, watchdog).
module tb_conv_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  src_valid;
    logic [1:0]  src_wvalid;
    logic [15:0] src_ifm0, src_ifm1;
    logic [15:0] src_wgt0, src_wgt1;
    logic [1:0]  gnt;
    logic        eng_in_valid, eng_weight_valid;
    logic [15:0] eng_ifm, eng_weight;
    logic        eng_out_valid;
    logic [35:0] eng_ofm;
    logic [1:0]  rsp_valid;
    logic [35:0] rsp_data;
    logic [1:0]  done;
    logic        err;

    int n_pass = 0;
    int n_tot  = 0;
    int gnt11  = 0;

    conv_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .src_valid        (src_valid),
        .src_wvalid       (src_wvalid),
        .src_ifm0         (src_ifm0),
        .src_ifm1         (src_ifm1),
        .src_wgt0         (src_wgt0),
        .src_wgt1         (src_wgt1),
        .gnt              (gnt),
        .eng_in_valid     (eng_in_valid),
        .eng_weight_valid (eng_weight_valid),
        .eng_ifm          (eng_ifm),
        .eng_weight       (eng_weight),
        .eng_out_valid    (eng_out_valid),
        .eng_ofm          (eng_ofm),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .done             (done),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gnt == 2'b11) gnt11++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  sv;
        logic [1:0]  swv;
        logic [15:0] i0, i1, w0, w1;
        logic        eov;
        logic [37:0] exp;   // {gnt, iv, wv, ifm, wgt, rsp_valid}
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [35:0] ofm_word(input int r, input int k);
        return {4'h9, 16'(r), 16'(k)};
    endfunction

    task automatic clr_inputs();
        req = 2'b00; src_valid = 2'b00; src_wvalid = 2'b00;
        src_ifm0 = 16'h0; src_ifm1 = 16'h0;
        src_wgt0 = 16'h0; src_wgt1 = 16'h0;
        eng_out_valid = 1'b0; eng_ofm = 36'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {gnt, eng_in_valid, eng_weight_valid,
                           rsp_valid, done, err}, 0);
        chk({nm, "_eng"}, {eng_ifm, eng_weight}, 0);
        chk({nm, "_rsp"}, rsp_data, 0);
    endtask

    task automatic wait_grant(input logic [1:0] oh, output int lat);
        lat = 0;
        while (gnt != oh && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("grant", gnt, oh);
    endtask

    task automatic stream(input int r, input int n, input int nwv);
        int nin = 0;
        int nw = 0;
        int nbad = 0;
        for (int i = 0; i < n; i++) begin
            src_valid  = 2'b11;
            src_wvalid = (i < nwv) ? 2'b11 : 2'b00;
            if (r == 0) begin
                src_ifm0 = 16'h1000 + 16'(i); src_ifm1 = 16'hE000 + 16'(i);
                src_wgt0 = 16'h2000 + 16'(i); src_wgt1 = 16'hF000 + 16'(i);
            end else begin
                src_ifm1 = 16'h1000 + 16'(i); src_ifm0 = 16'hE000 + 16'(i);
                src_wgt1 = 16'h2000 + 16'(i); src_wgt0 = 16'hF000 + 16'(i);
            end
            @(negedge clk);
            if (eng_in_valid) begin
                nin++;
                if (eng_ifm != 16'h1000 + 16'(i)) nbad++;
            end
            if (eng_weight_valid) begin
                nw++;
                if (eng_weight != 16'h2000 + 16'(i)) nbad++;
            end
            @(posedge clk); #1;
        end
        src_valid = 2'b00; src_wvalid = 2'b00;
        chk("ifm_count", nin, 49);
        chk("wgt_count", nw, 9);
        chk("stream_data", nbad, 0);
    endtask

    // n_res < 25 aborts with reset right after result n_res is visible
    task automatic engine(input int r, input int n_res);
        logic [1:0] oh;
        int nrsp = 0;
        int nbad = 0;
        int ndone = 0;
        int ngnt = 0;
        oh = 2'b01 << r;
        for (int k = 0; k <= n_res; k++) begin
            eng_out_valid = (k < n_res);
            eng_ofm = ofm_word(r, k);
            @(negedge clk);
            if (k == 0) begin
                if (rsp_valid != 2'b00) nbad++;
            end else if (rsp_valid == oh && rsp_data == ofm_word(r, k - 1)) begin
                nrsp++;
            end else begin
                nbad++;
            end
            if (done == oh && k == 25) ndone++;
            else if (done != 2'b00) nbad++;
            if (k < n_res) begin
                if (gnt != oh) ngnt++;
                @(posedge clk); #1;
            end
        end
        eng_out_valid = 1'b0;
        chk("rsp_count", nrsp, n_res);
        chk("rsp_bad", nbad, 0);
        chk("done_count", ndone, (n_res == 25) ? 1 : 0);
        chk("gnt_held", ngnt, 0);
        if (n_res == 25) begin
            @(posedge clk); #1;
            chk("done_pulse", {done, rsp_valid, rsp_data}, 0);
        end else begin
            rst_n = 1'b0;
            src_valid = 2'b11; src_wvalid = 2'b11;
            #1;
            chk_all_zero("abort");
            @(posedge clk); #1;
            chk("abort_done", done, 0);
            rst_n = 1'b1;
            clr_inputs();
        end
    endtask

    initial begin : main
        int lat;
        int t;
        rst_n = 1'b0;
        clr_inputs();
        #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        tbl[0] = '{2'b00, 2'b11, 2'b11, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 1'b1,
                   {2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00}};
        tbl[1] = '{2'b10, 2'b11, 2'b11, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 1'b0,
                   {2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00}};
        tbl[2] = '{2'b11, 2'b01, 2'b01, 16'h1234, 16'h5678, 16'h1111, 16'h2222, 1'b0,
                   {2'b10, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00}};
        tbl[3] = '{2'b00, 2'b10, 2'b10, 16'h1234, 16'h0AB1, 16'h1111, 16'h0C01, 1'b0,
                   {2'b10, 1'b1, 1'b1, 16'h0AB1, 16'h0C01, 2'b00}};
        tbl[4] = '{2'b00, 2'b11, 2'b01, 16'h1234, 16'h0AB2, 16'h1111, 16'h0C02, 1'b0,
                   {2'b10, 1'b1, 1'b0, 16'h0AB2, 16'h0000, 2'b00}};
        tbl[5] = '{2'b01, 2'b10, 2'b10, 16'h1234, 16'h0AB3, 16'h1111, 16'h0C03, 1'b1,
                   {2'b10, 1'b1, 1'b1, 16'h0AB3, 16'h0C03, 2'b00}};
        tbl[6] = '{2'b00, 2'b00, 2'b00, 16'h1234, 16'h0AB4, 16'h1111, 16'h0C04, 1'b0,
                   {2'b10, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00}};
        tbl[7] = '{2'b00, 2'b10, 2'b00, 16'h1234, 16'h0AB4, 16'h1111, 16'h0C04, 1'b1,
                   {2'b10, 1'b1, 1'b0, 16'h0AB4, 16'h0000, 2'b00}};
        tbl[8] = '{2'b00, 2'b00, 2'b00, 16'h1234, 16'h0AB5, 16'h1111, 16'h0C05, 1'b0,
                   {2'b10, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00}};

        eng_ofm = 36'h5_5555_5555;
        for (int i = 0; i < 9; i++) begin
            req = tbl[i].req; src_valid = tbl[i].sv; src_wvalid = tbl[i].swv;
            src_ifm0 = tbl[i].i0; src_ifm1 = tbl[i].i1;
            src_wgt0 = tbl[i].w0; src_wgt1 = tbl[i].w1;
            eng_out_valid = tbl[i].eov;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {gnt, eng_in_valid, eng_weight_valid, eng_ifm, eng_weight, rsp_valid},
                tbl[i].exp);
            @(posedge clk); #1;
        end

        // single requester 0 job
        do_reset();
        req = 2'b01;
        wait_grant(2'b01, lat);
        chk("grant_lat", lat, 1);
        req = 2'b00;
        stream(0, 49, 9);
        repeat (2) begin
            @(negedge clk);
            chk("wait_gnt", {gnt, rsp_valid}, {2'b01, 2'b00});
            @(posedge clk); #1;
        end
        engine(0, 25);

        // both requesting: 0 first, then 1 from the pending req; 52 words
        do_reset();
        req = 2'b11;
        wait_grant(2'b01, lat);
        chk("rr_lat", lat, 1);
        req = 2'b10;
        stream(0, 49, 9);
        engine(0, 25);
        wait_grant(2'b10, lat);
        req = 2'b00;
        stream(1, 52, 12);
        engine(1, 25);

        // reset mid-DRAIN after result 10
        do_reset();
        req = 2'b01;
        wait_grant(2'b01, lat);
        req = 2'b00;
        stream(0, 49, 9);
        engine(0, 10);
        req = 2'b11;
        wait_grant(2'b01, lat);
        chk("ptr_reset_lat", lat, 1);
        do_reset();
        req = 2'b10;
        wait_grant(2'b10, lat);
        chk("req1_lat", lat, 1);

        // engine silent in WAIT
        do_reset();
        req = 2'b01;
        wait_grant(2'b01, lat);
        req = 2'b00;
        stream(0, 49, 9);
`ifdef CONV_ARB_TIMEOUT_EN
        t = 0;
        while (err !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("tmo_cycles", t, 64);
        chk("tmo_done", done, 0);
        @(posedge clk); #1;
        chk("tmo_after", {gnt, err, done}, 0);
`else
        t = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (err) t++;
        end
        chk("no_tmo_err", t, 0);
        chk("no_tmo_gnt", gnt, 2'b01);
`endif
        do_reset();

        chk("gnt_never_11", gnt11, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/conv_arbiter.md
CONV_ARBITER -- requirements
Module: conv_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- N_IFM, 49: IFM words per job.
- N_WGT, 9: weight words per job.
- N_OFM, 25: result words per job.
- TIMEOUT, 64: WAIT-state watchdog limit, in cycles.

REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all logic is clocked on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  per-requester job request.
- src_valid  in  2  per-requester IFM word valid.
- src_wvalid  in  2  per-requester weight word valid.
- src_ifm0, src_ifm1  in  16  per-requester IFM data.
- src_wgt0, src_wgt1  in  16  per-requester weight data.
- gnt  out  2  one-hot grant.
- eng_in_valid  out  1  IFM valid to the convolution engine.
- eng_weight_valid  out  1  weight valid to the engine.
- eng_ifm  out  16  IFM data to the engine.
- eng_weight  out  16  weight data to the engine.
- eng_out_valid  in  1  engine result valid.
- eng_ofm  in  36  engine result.
- rsp_valid  out  2  one-hot per-requester result valid.
- rsp_data  out  36  result data.
- done  out  2  one-cycle job-complete pulse, per requester.
- err  out  1  one-cycle watchdog pulse.

Function
REQ-003 The block SHALL share one 7x7-IFM / 3x3-weight convolution engine between two requesters, one job at a time.
REQ-004 The FSM SHALL have four states with these transitions:
- IDLE->LOAD when any req bit is high.
- LOAD->WAIT after the N_IFM-th granted IFM word.
- WAIT->DRAIN on the first eng_out_valid.
- DRAIN->IDLE after the N_OFM-th result is forwarded.
REQ-005 Arbitration SHALL be round-robin: when both req bits are high in IDLE, the requester not served last wins; after reset, requester 0 has priority.
REQ-006 gnt SHALL be registered, asserted the cycle after the IDLE->LOAD decision, and held through the last DRAIN cycle.
REQ-007 req SHALL be ignored while a job is granted; a losing or late req stays pending and is arbitrated at the next IDLE.
REQ-008 In LOAD, eng_in_valid/eng_ifm SHALL be the granted src_valid/src_ifm, and eng_weight_valid/eng_weight the granted src_wvalid/src_wgt, combinationally muxed with zero added latency.
REQ-009 Words after the N_IFM-th IFM word or the N_WGT-th weight word SHALL be masked (engine valid held 0); the non-granted source SHALL always be masked.
REQ-010 Requesters SHALL stream IFM words contiguously; the arbiter does not repair gaps.
REQ-011 eng_out_valid SHALL be ignored outside WAIT/DRAIN.
REQ-012 Each eng_ofm word SHALL appear on rsp_data one cycle after eng_out_valid, with rsp_valid set at the granted bit; rsp_data SHALL be 0 when rsp_valid is 0.
REQ-013 The done bit for the granted requester SHALL pulse in the same cycle as the N_OFM-th rsp_valid.
REQ-014 The word and result counters SHALL be 6-bit, clear on entry to IDLE, and never wrap within a job.

Reset
REQ-015 rst_n low SHALL asynchronously force IDLE and clear all counters.
REQ-016 rst_n low SHALL drive gnt, eng_in_valid, eng_weight_valid, eng_ifm, eng_weight, rsp_valid, rsp_data, done and err to 0, and reset the round-robin pointer to requester 0.
REQ-017 Reset asserted mid-job SHALL abandon the job without issuing done.

Configuration
REQ-018 With CONV_ARB_TIMEOUT_EN defined, TIMEOUT cycles in WAIT without eng_out_valid SHALL pulse err for one cycle, drop gnt, and return to IDLE without done.
REQ-019 With CONV_ARB_TIMEOUT_EN undefined, WAIT SHALL wait indefinitely and err SHALL be tied to 0.

Structure
REQ-020 A shared package conv_pkg SHALL hold the FSM state typedef (IDLE, LOAD, WAIT, DRAIN) and the N_IFM, N_WGT and N_OFM constants.
REQ-021 The round-robin arbiter SHALL be one sub-module, rr_arb2, combinational with a registered pointer.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- req=01, 49 IFM words with 9 weights in the first 9 cycles, engine returns 25 results -> gnt=01 one cycle later, 25 rsp_valid=01 each one cycle after eng_out_valid, done=01 on the 25th.
- req=11 in IDLE after reset -> requester 0 served first, then requester 1 without a new req edge; gnt never 11.
- Requester streams 52 IFM words -> exactly 49 eng_in_valid cycles.
- eng_out_valid pulsed during LOAD -> no rsp_valid.
- rst_n low during DRAIN after result 10 -> all outputs 0 immediately, no done, next req=10 served by requester 1 only after the pointer resets.
- CONV_ARB_TIMEOUT_EN defined, engine silent -> err pulse exactly 64 cycles after WAIT entry, gnt=00 the next cycle.
